// File: rtl/seq_divide.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, ready/valid on both sides.
// Define SEQ_DIVIDE_SIGNED_EN for two's-complement operands (adds one sign fix-up cycle).
module seq_divide #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

`ifdef SEQ_DIVIDE_SIGNED_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, qr, dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial, diff;
    logic             ge, last, accept, dz;
    logic [WIDTH-1:0] acc_n, qr_n, dd_op, dv_op;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign dz        = (divisor == '0);
    assign last      = (cnt == CW'(WIDTH-1));

`ifdef SEQ_DIVIDE_SIGNED_EN
    logic dd_neg, dv_neg, qneg, rneg;
    assign dd_neg = dividend[WIDTH-1];
    assign dv_neg = divisor[WIDTH-1];
    assign dd_op  = dd_neg ? -dividend : dividend;
    assign dv_op  = dv_neg ? -divisor  : divisor;
`else
    assign dd_op = dividend;
    assign dv_op = divisor;
`endif

    // Trial remainder is WIDTH+1 bits; the borrow out of the subtract is the compare result.
    assign trial = {acc, qr[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs};
    assign ge    = ~diff[WIDTH];
    assign acc_n = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign qr_n  = {qr[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = dz ? DONE : BUSY;
`ifdef SEQ_DIVIDE_SIGNED_EN
            BUSY: if (last) state_n = FIX;
            FIX:  state_n = DONE;
`else
            BUSY: if (last) state_n = DONE;
`endif
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            qr          <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDE_SIGNED_EN
            qneg        <= 1'b0;
            rneg        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dvs <= dv_op;
                    qr  <= dd_op;
                    acc <= '0;
                    cnt <= '0;
`ifdef SEQ_DIVIDE_SIGNED_EN
                    qneg <= dd_neg ^ dv_neg;
                    rneg <= dd_neg;
`endif
                    // Zero divisor skips the iterations; raw dividend is reported as remainder.
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end
                end
                BUSY: begin
                    acc <= acc_n;
                    qr  <= qr_n;
                    cnt <= cnt + CW'(1);
`ifndef SEQ_DIVIDE_SIGNED_EN
                    if (last) begin
                        quotient    <= qr_n;
                        remainder   <= acc_n;
                        div_by_zero <= 1'b0;
                    end
`endif
                end
`ifdef SEQ_DIVIDE_SIGNED_EN
                FIX: begin
                    quotient    <= qneg ? -qr : qr;
                    remainder   <= rneg ? -acc : acc;
                    div_by_zero <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divide.sv
// Scoreboard bench for seq_divide: WIDTH=8 directed/backpressure/reset cases and WIDTH=4 exhaustive sweep.
module tb_seq_divide;
`ifdef SEQ_DIVIDE_SIGNED_EN
    localparam int LAT8 = 10;
    localparam int LAT4 = 6;
`else
    localparam int LAT8 = 9;
    localparam int LAT4 = 5;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv8 = 1'b0, or8 = 1'b0, ir8, ov8, z8;
    logic [7:0] a8 = '0, b8 = '0, q8, r8;
    logic       iv4 = 1'b0, or4 = 1'b0, ir4, ov4, z4;
    logic [3:0] a4 = '0, b4 = '0, q4, r4;

    exp_t sb8[$];
    exp_t sb4[$];
    int   vecs = 0;
    int   fails = 0;

    seq_divide #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .dividend(a8), .divisor(b8), .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    seq_divide #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .dividend(a4), .divisor(b4), .out_valid(ov4), .out_ready(or4),
        .quotient(q4), .remainder(r4), .div_by_zero(z4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] m;
`ifdef SEQ_DIVIDE_SIGNED_EN
        int sa, sd;
`endif
        m = (32'h1 << w) - 32'h1;
        if (b == 0) begin
            e.q = m; e.r = a; e.z = 1'b1;
        end else begin
`ifdef SEQ_DIVIDE_SIGNED_EN
            sa  = a[w-1] ? int'(a) - (1 << w) : int'(a);
            sd  = b[w-1] ? int'(b) - (1 << w) : int'(b);
            e.q = 32'(sa / sd) & m;
            e.r = 32'(sa % sd) & m;
`else
            e.q = a / b;
            e.r = a % b;
`endif
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic pop8(input string tag);
        exp_t e;
        if (sb8.size() == 0) begin
            chk({tag, "/sb_empty"}, 1, 0);
        end else begin
            e = sb8.pop_front();
            chk({tag, "/q"}, 32'(q8), e.q);
            chk({tag, "/r"}, 32'(r8), e.r);
            chk({tag, "/z"}, 32'(z8), 32'(e.z));
        end
    endtask

    task automatic wait8(input string tag, input int elat);
        int lat;
        lat = 1;
        while (!ov8 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/lat"}, lat, elat);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                       input logic [7:0] er, input logic ez, input int elat, input string tag);
        exp_t e;
        e.q = 32'(eq); e.r = 32'(er); e.z = ez;
        sb8.push_back(e);
        chk({tag, "/rdy"}, 32'(ir8), 1);
        a8 = a; b8 = b; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        wait8(tag, elat);
        pop8(tag);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk({tag, "/rdy_after"}, 32'(ir8), 1);
        chk({tag, "/ov_after"}, 32'(ov8), 0);
        chk({tag, "/q_hold"}, 32'(q8), 32'(eq));
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   lat;
        string tag;
        tag = $sformatf("w4_%0d_%0d", a, b);
        e = model(4, 32'(a), 32'(b));
        sb4.push_back(e);
        a4 = a; b4 = b; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 1;
        while (!ov4 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/lat"}, lat, (b == 0) ? 1 : LAT4);
        e = sb4.pop_front();
        chk({tag, "/q"}, 32'(q4), e.q);
        chk({tag, "/r"}, 32'(r4), e.r);
        chk({tag, "/z"}, 32'(z4), 32'(e.z));
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    initial begin
        bit seen;
        exp_t e;

        #2;
        chk("rst/ir", 32'(ir8), 1);
        chk("rst/ov", 32'(ov8), 0);
        chk("rst/q", 32'(q8), 0);
        chk("rst/r", 32'(r8), 0);
        chk("rst/z", 32'(z8), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef SEQ_DIVIDE_SIGNED_EN
        op8(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, LAT8, "s_m7_2");
        op8(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT8, "s_min_m1");
        op8(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, LAT8, "s_7_m2");
        op8(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, LAT8, "s_m100_7");
        op8(8'd13, 8'd0, 8'hFF, 8'd13, 1'b1, 1, "s_13_0");
`else
        op8(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, LAT8, "200_7");
        op8(8'd13, 8'd0, 8'd255, 8'd13, 1'b1, 1, "13_0");
        op8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT8, "255_1");
        op8(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT8, "255_255");
        op8(8'd5, 8'd200, 8'd0, 8'd5, 1'b0, LAT8, "5_200");
        op8(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, LAT8, "0_5");
`endif

        // Backpressure: result held for 5 cycles while in_valid pulses must be ignored.
        e.q = 32'd14; e.r = 32'd2; e.z = 1'b0;
        sb8.push_back(e);
        a8 = 8'd100; b8 = 8'd7; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        wait8("bp", LAT8);
        for (int i = 0; i < 5; i++) begin
            iv8 = i[0]; a8 = 8'($urandom); b8 = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            chk($sformatf("bp%0d/ov", i), 32'(ov8), 1);
            chk($sformatf("bp%0d/ir", i), 32'(ir8), 0);
            chk($sformatf("bp%0d/q", i), 32'(q8), 14);
            chk($sformatf("bp%0d/r", i), 32'(r8), 2);
        end
        iv8 = 1'b0;
        pop8("bp");
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("bp/ir_after", 32'(ir8), 1);
        @(posedge clk); #1;
        chk("bp/no_ghost", 32'(ov8), 0);

        // Reset mid-operation: the aborted 100/3 must never produce a result.
        a8 = 8'd100; b8 = 8'd3; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ar/ov", 32'(ov8), 0);
        chk("ar/q", 32'(q8), 0);
        chk("ar/r", 32'(r8), 0);
        chk("ar/z", 32'(z8), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ar/ir", 32'(ir8), 1);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov8) seen = 1'b1;
        end
        chk("ar/never_valid", 32'(seen), 0);
        op8(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, LAT8, "ar_9_3");

`ifndef SEQ_DIVIDE_SIGNED_EN
        chk("w4/15_1_model_q", model(4, 32'd15, 32'd1).q, 32'd15);
        chk("w4/7_8_model_r", model(4, 32'd7, 32'd8).r, 32'd7);
`endif
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(4'(a), 4'(b));

        chk("sb8_drained", sb8.size(), 0);
        chk("sb4_drained", sb4.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/seq_divide.md
SEQ_DIVIDE -- requirements
Module: seq_divide

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/quotient/remainder width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port dividend  input  WIDTH  numerator.
REQ-007 SHALL have port divisor  input  WIDTH  denominator.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  WIDTH  result quotient.
REQ-011 SHALL have port remainder  output  WIDTH  result remainder.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero for the current result.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->BUSY on accept with nonzero divisor, IDLE->DONE on accept with zero divisor, BUSY->DONE after WIDTH iterations, DONE->IDLE on out_ready.
REQ-014 SHALL assert in_ready only in IDLE; accept = in_valid && in_ready; operands SHALL be captured at accept and later input changes ignored.
REQ-015 SHALL compute one quotient bit per BUSY cycle, MSB first, by restoring shift-subtract using a WIDTH+1-bit partial remainder with no truncation of the compare.
REQ-016 SHALL assert out_valid exactly WIDTH+1 cycles after the accepting edge for nonzero divisor, and 1 cycle after for zero divisor.
REQ-017 SHALL assert out_valid only in DONE and hold quotient, remainder, div_by_zero stable while out_valid && !out_ready.
REQ-018 SHALL, on divisor == 0, produce quotient = all ones, remainder = dividend, div_by_zero = 1; otherwise div_by_zero = 0.
REQ-019 SHALL produce unsigned results with dividend = quotient*divisor + remainder and remainder < divisor.
REQ-020 SHALL, with out_valid && out_ready in DONE, return to IDLE next cycle; next accept earliest one cycle after handshake (no same-cycle accept).
REQ-021 SHALL keep quotient/remainder/div_by_zero holding last result in IDLE and updating only on entry to DONE.

Reset
REQ-022 SHALL, on rst_n low, immediately (asynchronously) enter IDLE and force in_ready=1 after release, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
REQ-023 SHALL abort any in-flight operation on reset with no result ever emitted for it.

Configuration
REQ-024 SHALL, with SEQ_DIVIDE_SIGNED_EN defined, treat operands as two's complement: divide magnitudes, quotient truncated toward zero, remainder sign = dividend sign, adding exactly one cycle of sign fix-up latency (out_valid at WIDTH+2 for nonzero divisor).
REQ-025 SHALL, with SEQ_DIVIDE_SIGNED_EN defined, return quotient = most-negative value, remainder = 0, div_by_zero = 0 for most-negative / -1; zero divisor per REQ-018.
REQ-026 SHALL, without SEQ_DIVIDE_SIGNED_EN, be purely unsigned with no sign logic or extra latency.

Verification
REQ-027 SHALL cover WIDTH=8 unsigned 200/7 -> quotient=28, remainder=4, div_by_zero=0, out_valid 9 cycles after accept.
REQ-028 SHALL cover WIDTH=8 13/0 -> quotient=255, remainder=13, div_by_zero=1, out_valid 1 cycle after accept.
REQ-029 SHALL cover WIDTH=4 exhaustive 256 operand pairs vs. reference model, including 15/1 -> 15 r0 and 7/8 -> 0 r7.
REQ-030 SHALL cover backpressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored, then handshake -> in_ready=1 next cycle.
REQ-031 SHALL cover rst_n asserted 3 cycles after accepting 100/3 -> out_valid never rises, in_ready=1 after release, next 9/3 -> 3 r0.
REQ-032 SHALL cover SEQ_DIVIDE_SIGNED_EN, WIDTH=8: -7/2 -> quotient=-3, remainder=-1; -128/-1 -> quotient=-128, remainder=0; out_valid 10 cycles after accept.
